// File: rtl/io_shutdown_pkg.sv
// Shared types and sizing helpers for the IO shutdown controller.
package io_shutdown_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SAFE  = 2'd1,
        ST_REARM = 2'd2
    } state_t;

    localparam int TRIP_CNT_W = 8;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/shutdown_debounce.sv
// Two-flop synchronizer followed by a symmetric debouncer for one shutdown source.
module shutdown_debounce
    import io_shutdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the current level restarts the count.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/io_shutdown_ctrl.sv
// Debounced multi-source shutdown gate for a GPIO/LED bus with first-cause latch and re-arm.
// Define IO_SHUTDOWN_TRISTATE_EN to float the bus (high-Z) instead of driving SAFE_VAL.
module io_shutdown_ctrl
    import io_shutdown_pkg::*;
#(
    parameter int                 NUM_IN          = 3,
    parameter int                 NUM_IOS         = 51,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 REARM_CYCLES    = 50000000,
    parameter bit                 AUTO_REARM      = 1'b1,
    parameter logic [NUM_IOS-1:0] SAFE_VAL        = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_IN-1:0]     shutdown,
    input  logic                  arm,
    input  logic [NUM_IOS-1:0]    gpio_in,
`ifdef IO_SHUTDOWN_TRISTATE_EN
    output wire  [NUM_IOS-1:0]    gpio_out,
`else
    output logic [NUM_IOS-1:0]    gpio_out,
`endif
    output logic                  shutdown_active,
    output logic [NUM_IN-1:0]     cause,
    output logic [TRIP_CNT_W-1:0] trip_count
);

    localparam int                  RA_W     = cnt_width(REARM_CYCLES - 1);
    localparam logic [RA_W-1:0]     RA_LAST  = RA_W'(REARM_CYCLES - 1);
`ifdef IO_SHUTDOWN_TRISTATE_EN
    localparam logic [NUM_IOS-1:0]  FORCE_VAL = '0;
`else
    localparam logic [NUM_IOS-1:0]  FORCE_VAL = SAFE_VAL;
`endif

    logic [NUM_IN-1:0]     w_level;
    logic                  w_any_src;

    state_t                r_state;
    logic [RA_W-1:0]       r_rearm_cnt;
    logic [NUM_IN-1:0]     r_cause;
    logic [TRIP_CNT_W-1:0] r_trip_cnt;
    logic [NUM_IOS-1:0]    r_gpio;
    logic                  r_oe;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_src
        shutdown_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .i_raw   (shutdown[g]),
            .o_level (w_level[g])
        );
    end

    assign w_any_src = |w_level;

    // Reset lands in REARM so the pins only go live after a full clean window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_REARM;
            r_rearm_cnt <= '0;
            r_cause     <= '0;
            r_trip_cnt  <= '0;
            r_gpio      <= FORCE_VAL;
            r_oe        <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_any_src) begin
                        r_state <= ST_SAFE;
                        r_cause <= w_level;
                        r_gpio  <= FORCE_VAL;
                        r_oe    <= 1'b0;
                        if (r_trip_cnt != '1)
                            r_trip_cnt <= r_trip_cnt + 1'b1;
                    end else begin
                        r_gpio  <= gpio_in;
                        r_oe    <= 1'b1;
                    end
                end
                ST_SAFE: begin
                    r_gpio <= FORCE_VAL;
                    r_oe   <= 1'b0;
                    if (!w_any_src && (AUTO_REARM || arm)) begin
                        r_state     <= ST_REARM;
                        r_rearm_cnt <= '0;
                    end
                end
                ST_REARM: begin
                    r_gpio <= FORCE_VAL;
                    r_oe   <= 1'b0;
                    if (w_any_src) begin
                        r_state     <= ST_SAFE;
                        r_rearm_cnt <= '0;
                    end else if (r_rearm_cnt == RA_LAST) begin
                        r_state     <= ST_RUN;
                        r_rearm_cnt <= '0;
                        r_cause     <= '0;
                    end else begin
                        r_rearm_cnt <= r_rearm_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_REARM;
                    r_rearm_cnt <= '0;
                    r_gpio      <= FORCE_VAL;
                    r_oe        <= 1'b0;
                end
            endcase
        end
    end

`ifdef IO_SHUTDOWN_TRISTATE_EN
    assign gpio_out = r_oe ? r_gpio : {NUM_IOS{1'bz}};
`else
    assign gpio_out = r_gpio;
`endif

    assign shutdown_active = (r_state != ST_RUN);
    assign cause           = r_cause;
    assign trip_count      = r_trip_cnt;

endmodule

// File: tb/tb_io_shutdown_ctrl.sv
// Self-checking bench: auto-rearm instance checked every cycle against a behavioural model,
// manual-rearm instance checked with directed expectations.
module tb_io_shutdown_ctrl;

    localparam int              NI  = 3;
    localparam int              NIO = 51;
    localparam int              DB  = 4;
    localparam int              RC  = 10;
    localparam logic [NIO-1:0]  SV  = 51'h5_A5A5_0F0F_3C3C;

    logic            clk;
    logic            rst_n;
    logic [NI-1:0]   sd, sd_m;
    logic            arm, arm_m;
    logic [NIO-1:0]  gin, gin_m;
    logic [NIO-1:0]  gout, gout_m;
    logic            act, act_m;
    logic [NI-1:0]   cause, cause_m;
    logic [7:0]      tc, tc_m;

    int tests = 0;
    int fails = 0;

    io_shutdown_ctrl #(
        .NUM_IN(NI), .NUM_IOS(NIO), .DEBOUNCE_CYCLES(DB), .REARM_CYCLES(RC),
        .AUTO_REARM(1'b1), .SAFE_VAL(SV)
    ) dut (
        .clk(clk), .reset_n(rst_n), .shutdown(sd), .arm(arm), .gpio_in(gin),
        .gpio_out(gout), .shutdown_active(act), .cause(cause), .trip_count(tc)
    );

    io_shutdown_ctrl #(
        .NUM_IN(NI), .NUM_IOS(NIO), .DEBOUNCE_CYCLES(DB), .REARM_CYCLES(RC),
        .AUTO_REARM(1'b0), .SAFE_VAL(SV)
    ) dut_m (
        .clk(clk), .reset_n(rst_n), .shutdown(sd_m), .arm(arm_m), .gpio_in(gin_m),
        .gpio_out(gout_m), .shutdown_active(act_m), .cause(cause_m), .trip_count(tc_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the auto-rearm instance: mode 0 = live, 1 = safe, 2 = rearm window.
    logic           m_s1 [NI];
    logic           m_s2 [NI];
    logic           m_lvl[NI];
    int             m_dis[NI];
    int             m_mode;
    int             m_clean;
    logic [NI-1:0]  m_cause;
    int             m_trips;
    logic [NIO-1:0] m_gout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NI-1:0] lv;
        for (int i = 0; i < NI; i++) lv[i] = m_lvl[i];
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0; m_dis[i] = 0;
            end
            m_mode = 2; m_clean = 0; m_cause = '0; m_trips = 0; m_gout = SV;
        end else begin
            if (m_mode == 0) begin
                if (lv != 0) begin
                    m_mode  = 1;
                    m_cause = lv;
                    m_trips = (m_trips < 255) ? m_trips + 1 : 255;
                    m_gout  = SV;
                end else begin
                    m_gout  = gin;
                end
            end else if (m_mode == 1) begin
                m_gout = SV;
                if (lv == 0) begin m_mode = 2; m_clean = 0; end
            end else begin
                m_gout = SV;
                if (lv != 0) begin
                    m_mode = 1; m_clean = 0;
                end else begin
                    m_clean++;
                    if (m_clean == RC) begin m_mode = 0; m_clean = 0; m_cause = '0; end
                end
            end
            // A source's level follows the synced input once it disagreed DB edges in a row.
            for (int i = 0; i < NI; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_dis[i]++;
                    if (m_dis[i] == DB) begin m_lvl[i] = m_s2[i]; m_dis[i] = 0; end
                end else begin
                    m_dis[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = sd[i];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gpio_out", 64'(gout), 64'(m_gout));
        chk("shutdown_active", 64'(act), 64'(m_mode != 0));
        chk("cause", 64'(cause), 64'(m_cause));
        chk("trip_count", 64'(tc), 64'(m_trips));
        gin   = NIO'({$urandom, $urandom});
        gin_m = NIO'({$urandom, $urandom});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (act !== 1'b0 && n < 100) begin step(); n++; end
        chk("wait_run", 64'(act), 64'(0));
    endtask

    initial begin
        int n;
        int hold;
        logic [NIO-1:0] g;

        rst_n = 1'b0; sd = '0; sd_m = '0; arm = 1'b0; arm_m = 1'b0;
        gin = '0; gin_m = '0;
        steps(3);
        chk("rst_gout", 64'(gout), 64'(SV));
        chk("rst_active", 64'(act), 64'(1));
        chk("rst_trip", 64'(tc), 64'(0));
        chk("rst_gout_m", 64'(gout_m), 64'(SV));

        // Clean rearm window after reset, then one cycle until pins follow gpio_in.
        rst_n = 1'b1;
        n = 0;
        while (act === 1'b1 && n < 50) begin step(); n++; end
        chk("rearm_len", 64'(n), 64'(RC));
        chk("run_first_gout", 64'(gout), 64'(SV));
        chk("run_m", 64'(act_m), 64'(0));
        g = gin;
        step();
        chk("run_track", 64'(gout), 64'(g));

        // Trip latency on source 2.
        sd = 3'b100;
        n = 0;
        while (act !== 1'b1 && n < 20) begin step(); n++; end
        chk("trip_latency", 64'(n), 64'(DB + 3));
        chk("trip_gout", 64'(gout), 64'(SV));
        chk("trip_cause", 64'(cause), 64'(3'b100));
        chk("trip_cnt1", 64'(tc), 64'(1));
        sd = '0;
        wait_run();

        // Glitch shorter than the debounce window is filtered.
        sd[0] = 1'b1; steps(3); sd[0] = 1'b0; steps(10);
        chk("glitch_no_trip", 64'(tc), 64'(1));
        chk("glitch_active", 64'(act), 64'(0));
        // A pulse exactly the debounce length does trip.
        sd[0] = 1'b1; steps(DB); sd[0] = 1'b0; steps(6);
        chk("pulse_db_trip", 64'(tc), 64'(2));
        chk("pulse_db_cause", 64'(cause), 64'(3'b001));
        wait_run();

        // Several sources together show up together in cause.
        sd = 3'b011; steps(8);
        chk("multi_cause", 64'(cause), 64'(3'b011));
        sd = '0;
        wait_run();

        // Source reasserts inside the rearm window.
        sd = 3'b001; steps(8); sd = '0;
        n = 0;
        while (m_mode != 2 && n < 50) begin step(); n++; end
        sd = 3'b010; steps(8);
        chk("reassert_active", 64'(act), 64'(1));
        chk("reassert_cause", 64'(cause), 64'(3'b001));
        chk("reassert_trips", 64'(tc), 64'(4));
        sd = '0;
        n = 0;
        while (m_mode != 2 && n < 50) begin step(); n++; end
        n = 0;
        while (act === 1'b1 && n < 50) begin step(); n++; end
        chk("reassert_rearm_len", 64'(n), 64'(RC));

        // Manual rearm instance.
        sd_m = 3'b001; steps(8);
        chk("m_trip_active", 64'(act_m), 64'(1));
        chk("m_trip_cause", 64'(cause_m), 64'(3'b001));
        chk("m_trip_cnt", 64'(tc_m), 64'(1));
        arm_m = 1'b1; step(); arm_m = 1'b0;
        sd_m = '0; steps(30);
        chk("m_arm_ignored", 64'(act_m), 64'(1));
        arm_m = 1'b1; step(); arm_m = 1'b0;
        steps(RC - 1);
        chk("m_rearm_hold", 64'(act_m), 64'(1));
        step();
        chk("m_run", 64'(act_m), 64'(0));
        chk("m_cause_clr", 64'(cause_m), 64'(0));

        // Random sources, pulse lengths and arm activity.
        hold = 0;
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                sd   = ($urandom_range(0, 2) == 0) ? NI'($urandom_range(1, 7)) : '0;
                hold = $urandom_range(1, 12);
            end
            hold--;
            arm = 1'($urandom_range(0, 1));
            step();
        end
        sd = '0; arm = 1'b0;
        wait_run();

        // Saturating trip counter.
        for (int k = 0; k < 300; k++) begin
            sd = 3'b001; steps(8);
            sd = '0;     steps(22);
        end
        chk("trip_saturate", 64'(tc), 64'(255));

        // Reset in the middle of SAFE.
        sd = 3'b001; steps(8);
        chk("pre_rst_active", 64'(act), 64'(1));
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midrst_cause", 64'(cause), 64'(0));
        chk("midrst_trips", 64'(tc), 64'(0));
        chk("midrst_active", 64'(act), 64'(1));
        chk("midrst_gout", 64'(gout), 64'(SV));
        sd = '0;
        steps(5);
        wait_run();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
